// File: rtl/uart_baud_ctrl.sv
// uart_baud_ctrl: baud-rate tick generator for a UART.
// Produces a TX bit tick, an RX oversample tick and an RX mid-bit sample
// strobe from a run-time programmable clocks-per-oversample-tick divisor.
// A divisor written while running is held pending and applied on the next
// TX bit boundary so a bit is never shortened.
module uart_baud_ctrl #(
  parameter int CLK_FREQ   = 32000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  input  logic             rx_realign,
  output logic             tx_tick,
  output logic             rx_os_tick,
  output logic             rx_sample,
  output logic [DIV_W-1:0] cur_div
);

  // Power-up divisor, rounded to nearest: (CLK + RATE/2) / RATE.
  localparam longint unsigned OS_RATE   = 64'(BAUD_RATE) * 64'(OVERSAMPLE);
  localparam longint unsigned RST_DIV_L = (64'(CLK_FREQ) + (OS_RATE / 64'd2)) / OS_RATE;
  localparam logic [DIV_W-1:0] RST_DIV  = RST_DIV_L[DIV_W-1:0];

  localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF_M1 = OS_W'((OVERSAMPLE / 2) - 1);
  localparam logic [OS_W-1:0]  OS_ZERO    = OS_W'(0);
  localparam logic [OS_W-1:0]  OS_ONE     = OS_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO   = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_TWO    = DIV_W'(2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PEND = 2'd2;

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_cur_div;
  logic [DIV_W-1:0] r_pend_div;
  logic [DIV_W-1:0] r_tx_div_cnt;
  logic [OS_W-1:0]  r_tx_os_cnt;
  logic [DIV_W-1:0] r_rx_div_cnt;
  logic [OS_W-1:0]  r_rx_os_cnt;
  logic             r_tx_tick;
  logic             r_rx_os_tick;
  logic             r_rx_sample;
  logic             r_cfg_err;
  logic             r_cfg_ready;

  logic [1:0]       w_state_nxt;
  logic [DIV_W-1:0] w_cur_div_nxt;
  logic [DIV_W-1:0] w_pend_div_nxt;
  logic [DIV_W-1:0] w_tx_div_nxt;
  logic [OS_W-1:0]  w_tx_os_nxt;
  logic [DIV_W-1:0] w_rx_div_nxt;
  logic [OS_W-1:0]  w_rx_os_nxt;

  logic             w_xfer;
  logic             w_div_ok;
  logic             w_run;
  logic [DIV_W-1:0] w_div_last;
  logic             w_tx_wrap;
  logic             w_tx_os_last;
  logic             w_rx_wrap;
  logic             w_rx_os_last;
  logic             w_tx_tick;
  logic             w_rx_os_tick;
  logic             w_rx_sample;
  logic [DIV_W-1:0] w_tx_div_inc;
  logic [OS_W-1:0]  w_tx_os_inc;
  logic [DIV_W-1:0] w_rx_div_inc;
  logic [OS_W-1:0]  w_rx_os_inc;

  assign w_xfer   = cfg_valid & r_cfg_ready;
  assign w_div_ok = (cfg_div >= DIV_TWO);
  assign w_run    = (r_state != S_IDLE) & enable;

  // Wrap compares use >= so a counter left above a smaller divisor still wraps.
  assign w_div_last   = r_cur_div - DIV_ONE;
  assign w_tx_wrap    = (r_tx_div_cnt >= w_div_last);
  assign w_tx_os_last = (r_tx_os_cnt >= OS_LAST);
  assign w_rx_wrap    = (r_rx_div_cnt >= w_div_last);
  assign w_rx_os_last = (r_rx_os_cnt >= OS_LAST);

  // A realign pulse overrides any rx wrap due on the same cycle.
  assign w_tx_tick    = w_run & w_tx_wrap & w_tx_os_last;
  assign w_rx_os_tick = w_run & ~rx_realign & w_rx_wrap;
  assign w_rx_sample  = w_rx_os_tick & (r_rx_os_cnt == OS_HALF_M1);

  // Free-running counter advance used whenever the generator is counting.
  always_comb begin
    w_tx_div_inc = w_tx_wrap ? DIV_ZERO : (r_tx_div_cnt + DIV_ONE);
    if (w_tx_wrap) begin
      w_tx_os_inc = w_tx_os_last ? OS_ZERO : (r_tx_os_cnt + OS_ONE);
    end else begin
      w_tx_os_inc = r_tx_os_cnt;
    end
    if (rx_realign) begin
      w_rx_div_inc = DIV_ZERO;
      w_rx_os_inc  = OS_ZERO;
    end else begin
      w_rx_div_inc = w_rx_wrap ? DIV_ZERO : (r_rx_div_cnt + DIV_ONE);
      if (w_rx_wrap) begin
        w_rx_os_inc = w_rx_os_last ? OS_ZERO : (r_rx_os_cnt + OS_ONE);
      end else begin
        w_rx_os_inc = r_rx_os_cnt;
      end
    end
  end

  // State, divisor and counter next-value selection.
  always_comb begin
    w_state_nxt    = r_state;
    w_cur_div_nxt  = r_cur_div;
    w_pend_div_nxt = r_pend_div;
    w_tx_div_nxt   = DIV_ZERO;
    w_tx_os_nxt    = OS_ZERO;
    w_rx_div_nxt   = DIV_ZERO;
    w_rx_os_nxt    = OS_ZERO;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && w_div_ok) begin
          w_cur_div_nxt = cfg_div;
        end else begin
          w_cur_div_nxt = r_cur_div;
        end
        if (enable) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (!enable) begin
          w_state_nxt = S_IDLE;
          if (w_xfer && w_div_ok) begin
            w_cur_div_nxt = cfg_div;
          end else begin
            w_cur_div_nxt = r_cur_div;
          end
        end else begin
          w_tx_div_nxt = w_tx_div_inc;
          w_tx_os_nxt  = w_tx_os_inc;
          w_rx_div_nxt = w_rx_div_inc;
          w_rx_os_nxt  = w_rx_os_inc;
          if (w_xfer && w_div_ok) begin
            w_pend_div_nxt = cfg_div;
            w_state_nxt    = S_PEND;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_PEND: begin
        if (!enable) begin
          w_state_nxt   = S_IDLE;
          w_cur_div_nxt = r_pend_div;
        end else if (w_tx_tick) begin
          // Bit boundary: swap divisor, counters restart from zero.
          w_state_nxt   = S_RUN;
          w_cur_div_nxt = r_pend_div;
        end else begin
          w_tx_div_nxt = w_tx_div_inc;
          w_tx_os_nxt  = w_tx_os_inc;
          w_rx_div_nxt = w_rx_div_inc;
          w_rx_os_nxt  = w_rx_os_inc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Register state, counters and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cur_div    <= RST_DIV;
      r_pend_div   <= DIV_ZERO;
      r_tx_div_cnt <= DIV_ZERO;
      r_tx_os_cnt  <= OS_ZERO;
      r_rx_div_cnt <= DIV_ZERO;
      r_rx_os_cnt  <= OS_ZERO;
      r_tx_tick    <= 1'b0;
      r_rx_os_tick <= 1'b0;
      r_rx_sample  <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_cfg_ready  <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cur_div    <= w_cur_div_nxt;
      r_pend_div   <= w_pend_div_nxt;
      r_tx_div_cnt <= w_tx_div_nxt;
      r_tx_os_cnt  <= w_tx_os_nxt;
      r_rx_div_cnt <= w_rx_div_nxt;
      r_rx_os_cnt  <= w_rx_os_nxt;
      r_tx_tick    <= w_tx_tick;
      r_rx_os_tick <= w_rx_os_tick;
      r_rx_sample  <= w_rx_sample;
      r_cfg_err    <= w_xfer & ~w_div_ok;
      r_cfg_ready  <= (w_state_nxt != S_PEND);
    end
  end

  assign cfg_ready  = r_cfg_ready;
  assign cfg_err    = r_cfg_err;
  assign tx_tick    = r_tx_tick;
  assign rx_os_tick = r_rx_os_tick;
  assign rx_sample  = r_rx_sample;
  assign cur_div    = r_cur_div;

endmodule
